// File: rtl/score_display_scan_if.sv
// Score display bus: score/load handshake in, conversion status and
// multiplexed active-low digit/segment drive out.
interface score_display_scan_if #(
  parameter int DIGITS  = 4,
  parameter int VALUE_W = 14
);
  logic [VALUE_W-1:0] value;
  logic               load;
  logic               blank_lz;
  logic               blink_en;
  logic               busy;
  logic               overflow;
  logic [DIGITS-1:0]  digit;
  logic [6:0]         display;

  modport master (
    output value, load, blank_lz, blink_en,
    input  busy, overflow, digit, display
  );

  modport slave (
    input  value, load, blank_lz, blink_en,
    output busy, overflow, digit, display
  );
endinterface

// File: rtl/score_display_scan.sv
// Binary score -> BCD via sequential double-dabble, then time-multiplexed
// onto an active-low seven-segment bus with blanking, overflow and blink.
module score_display_scan #(
  parameter int DIGITS       = 4,
  parameter int VALUE_W      = 14,
  parameter int SCAN_PERIOD  = 100000,
  parameter int BLINK_PERIOD = 25000000
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  score_display_scan_if.slave  io_bus
);
  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          STEP_W  = $clog2(VALUE_W + 1);
  localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          SCAN_W  = $clog2(SCAN_PERIOD);
  localparam int          BLINK_W = $clog2(BLINK_PERIOD);
  localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    for (int n = 0; n < DIGITS; n++) begin
      if (b[4*n +: 4] >= 4'd5) r[4*n +: 4] = b[4*n +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0000001;
      4'd1:    seg7 = 7'b1001111;
      4'd2:    seg7 = 7'b0010010;
      4'd3:    seg7 = 7'b0000110;
      4'd4:    seg7 = 7'b1001100;
      4'd5:    seg7 = 7'b0100100;
      4'd6:    seg7 = 7'b0100000;
      4'd7:    seg7 = 7'b0001111;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0000100;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t              r_state, w_state_nxt;
  logic [STEP_W-1:0]   r_step, w_step_nxt;
  logic                r_ovf_pend, w_ovf_pend_nxt;
  logic                w_capture, w_commit;
  logic [VALUE_W-1:0]  r_bin;
  logic [BCD_W-1:0]    r_bcd, w_bcd_adj, w_bcd_shift;
  logic [BCD_W-1:0]    r_buf;
  logic                r_overflow;
  logic [SCAN_W-1:0]   r_scan_cnt;
  logic [IDX_W-1:0]    r_idx;
  logic [BLINK_W-1:0]  r_blink_cnt;
  logic                r_blink_off;
  logic [DIGITS-1:0]   r_digit, w_digit_nxt;
  logic [6:0]          r_display, w_display_nxt;
  logic [3:0]          w_nib;
  logic                w_upper_zero;

  assign w_bcd_adj   = add3_all(r_bcd);
  assign w_bcd_shift = {w_bcd_adj[BCD_W-2:0], r_bin[VALUE_W-1]};

  always_comb begin
    w_state_nxt    = r_state;
    w_step_nxt     = r_step;
    w_ovf_pend_nxt = r_ovf_pend;
    w_capture      = 1'b0;
    w_commit       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.load) begin
          w_capture      = 1'b1;
          w_state_nxt    = S_SHIFT;
          w_step_nxt     = '0;
          w_ovf_pend_nxt = (32'(io_bus.value) > MAX_VAL);
        end
      end
      S_SHIFT: begin
        w_step_nxt = r_step + STEP_W'(1);
        if (r_step == STEP_W'(VALUE_W - 1)) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_step     <= '0;
      r_ovf_pend <= 1'b0;
      r_buf      <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_step     <= w_step_nxt;
      r_ovf_pend <= w_ovf_pend_nxt;
      // Final shift lands straight in the buffer so it only ever holds whole values.
      if (w_commit) begin
        r_buf      <= w_bcd_shift;
        r_overflow <= r_ovf_pend;
      end
    end
  end

  // Work registers are pure data: only meaningful while SHIFT is active.
  always_ff @(posedge i_clk) begin
    if (w_capture) begin
      r_bin <= io_bus.value;
      r_bcd <= '0;
    end else if (r_state == S_SHIFT) begin
      r_bin <= r_bin << 1;
      r_bcd <= w_bcd_shift;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scan_cnt  <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_blink_off <= 1'b0;
    end else begin
      if (r_scan_cnt == SCAN_W'(SCAN_PERIOD - 1)) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + IDX_W'(1);
      end else begin
        r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
      end
      if (r_blink_cnt == BLINK_W'(BLINK_PERIOD - 1)) begin
        r_blink_cnt <= '0;
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
      end
    end
  end

  always_comb begin
    w_nib        = r_buf[4*r_idx +: 4];
    w_upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((IDX_W'(j) >= r_idx) && (r_buf[4*j +: 4] != 4'd0)) w_upper_zero = 1'b0;
    end
    w_digit_nxt   = ~(DIGITS'(1) << r_idx);
    w_display_nxt = seg7(w_nib);
    if (r_overflow) begin
      w_display_nxt = 7'b1111110;
    end else if (io_bus.blank_lz && (r_idx != '0) && w_upper_zero) begin
      w_display_nxt = 7'b1111111;
    end
    if (io_bus.blink_en && r_blink_off) begin
      w_digit_nxt   = '1;
      w_display_nxt = 7'b1111111;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit   <= '1;
      r_display <= 7'b1111111;
    end else begin
      r_digit   <= w_digit_nxt;
      r_display <= w_display_nxt;
    end
  end

  assign io_bus.busy     = (r_state == S_SHIFT);
  assign io_bus.overflow = r_overflow;
  assign io_bus.digit    = r_digit;
  assign io_bus.display  = r_display;
endmodule

// File: tb/tb_score_display_scan.sv
// Randomized bench for score_display_scan against an arithmetic model of
// the displayed score, scan position and blink phase.
module tb_score_display_scan;
  localparam int DIGITS       = 4;
  localparam int VALUE_W      = 14;
  localparam int SCAN_PERIOD  = 4;
  localparam int BLINK_PERIOD = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  score_display_scan_if #(.DIGITS(DIGITS), .VALUE_W(VALUE_W)) bus();

  score_display_scan #(
    .DIGITS(DIGITS), .VALUE_W(VALUE_W),
    .SCAN_PERIOD(SCAN_PERIOD), .BLINK_PERIOD(BLINK_PERIOD)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .io_bus(bus)
  );

  always #5 clk = ~clk;

  logic [6:0] SEG [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                           7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  int total = 0;
  int bad   = 0;
  int n;
  int cv;
  bit ovf;
  bit pend;
  int pend_val;
  int pend_edge;

  function automatic int pow10(input int e);
    int p = 1;
    for (int i = 0; i < e; i++) p = p * 10;
    return p;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  task automatic model_reset();
    n    = 0;
    cv   = 0;
    ovf  = 1'b0;
    pend = 1'b0;
  endtask

  task automatic step_cycle();
    int idx;
    bit boff;
    bit busy_pre;
    logic [DIGITS-1:0] exp_dig;
    logic [6:0] exp_disp;
    @(posedge clk);
    n++;
    idx  = ((n - 1) / SCAN_PERIOD) % DIGITS;
    boff = (((n - 1) / BLINK_PERIOD) % 2) == 1;
    exp_dig  = ~(DIGITS'(1) << idx);
    if (ovf) exp_disp = 7'b1111110;
    else if (bus.blank_lz && idx > 0 && (cv / pow10(idx)) == 0) exp_disp = 7'b1111111;
    else exp_disp = SEG[(cv / pow10(idx)) % 10];
    if (bus.blink_en && boff) begin
      exp_dig  = '1;
      exp_disp = 7'b1111111;
    end
    busy_pre = pend;
    if (pend && pend_edge == n) begin
      cv   = pend_val;
      ovf  = cv > pow10(DIGITS) - 1;
      pend = 1'b0;
    end
    if (bus.load && !busy_pre) begin
      pend      = 1'b1;
      pend_val  = int'(bus.value);
      pend_edge = n + VALUE_W;
    end
    #1;
    check_val("digit",    32'(bus.digit),    32'(exp_dig));
    check_val("display",  32'(bus.display),  32'(exp_disp));
    check_val("busy",     32'(bus.busy),     32'(pend));
    check_val("overflow", 32'(bus.overflow), 32'(ovf));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step_cycle();
  endtask

  task automatic load_val(input int v);
    bus.value = VALUE_W'(v);
    bus.load  = 1'b1;
    step_cycle();
    bus.load  = 1'b0;
    run(VALUE_W + 1 + DIGITS * SCAN_PERIOD);
  endtask

  function automatic int rand_value();
    case ($urandom_range(0, 4))
      0:       return int'($urandom_range(0, 9));
      1:       return int'($urandom_range(0, 99));
      2:       return int'($urandom_range(0, 9999));
      3:       return int'($urandom_range(9990, 10010));
      default: return int'($urandom_range(0, (1 << VALUE_W) - 1));
    endcase
  endfunction

  initial begin
    bus.value    = '0;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;
    model_reset();
    #7;
    check_val("rst_digit",    32'(bus.digit),    32'({DIGITS{1'b1}}));
    check_val("rst_display",  32'(bus.display),  32'h7f);
    check_val("rst_busy",     32'(bus.busy),     32'd0);
    check_val("rst_overflow", 32'(bus.overflow), 32'd0);
    #1 rst_n = 1'b1;

    run(12);
    load_val(1234);
    bus.blank_lz = 1'b1;
    load_val(9);
    load_val(1005);
    load_val(10000);
    load_val(0);
    bus.blank_lz = 1'b0;

    bus.blink_en = 1'b1;
    run(4 * BLINK_PERIOD);
    bus.blink_en = 1'b0;

    bus.load = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.value = VALUE_W'(rand_value());
      step_cycle();
    end
    bus.load = 1'b0;
    run(VALUE_W + DIGITS * SCAN_PERIOD);

    for (int i = 0; i < 1500; i++) begin
      bus.value = VALUE_W'(rand_value());
      bus.load  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 29) == 0) bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(0, 39) == 0) bus.blink_en = ~bus.blink_en;
      if ($urandom_range(0, 99) == 0) begin
        bus.load = 1'b1;
        for (int j = 0; j < 20; j++) begin
          bus.value = VALUE_W'(rand_value());
          step_cycle();
        end
        bus.load = 1'b0;
      end
      step_cycle();
    end

    bus.load     = 1'b0;
    bus.blink_en = 1'b0;
    bus.blank_lz = 1'b0;
    load_val(10000);
    bus.value = VALUE_W'(4321);
    bus.load  = 1'b1;
    step_cycle();
    bus.load  = 1'b0;
    run(5);
    #2 rst_n = 1'b0;
    #1;
    check_val("midrst_digit",    32'(bus.digit),    32'({DIGITS{1'b1}}));
    check_val("midrst_display",  32'(bus.display),  32'h7f);
    check_val("midrst_busy",     32'(bus.busy),     32'd0);
    check_val("midrst_overflow", 32'(bus.overflow), 32'd0);
    #3 rst_n = 1'b1;
    model_reset();
    run(VALUE_W + 2 * DIGITS * SCAN_PERIOD);
    load_val(56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
